// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, one-hot flag indices
// and the decoded-instruction record passed from decode to execute.
package core_pkg;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int F_ADDI  = 0,  F_SLTI  = 1,  F_SLTIU = 2,  F_XORI  = 3,  F_ORI   = 4;
    localparam int F_ANDI  = 5,  F_SLLI  = 6,  F_SRLI  = 7,  F_SRAI  = 8,  F_ADD   = 9;
    localparam int F_SUB   = 10, F_SLL   = 11, F_SLT   = 12, F_SLTU  = 13, F_XOR   = 14;
    localparam int F_SRL   = 15, F_SRA   = 16, F_OR    = 17, F_AND   = 18, F_BEQ   = 19;
    localparam int F_BNE   = 20, F_BLT   = 21, F_BGE   = 22, F_BLTU  = 23, F_BGEU  = 24;
    localparam int F_LB    = 25, F_LH    = 26, F_LW    = 27, F_LBU   = 28, F_LHU   = 29;
    localparam int F_SB    = 30, F_SH    = 31, F_SW    = 32, F_LUI   = 33, F_AUIPC = 34;
    localparam int F_JAL   = 35, F_JALR  = 36;
    localparam int OP_W    = 37;

    // pc is carried at a fixed maximum width; the top truncates to its PC_W
    localparam int PC_MAX_W = 64;

    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [31:0]         imm;
        logic                illegal;
        logic [PC_MAX_W-1:0] pc;
    } dec_t;

endpackage

// File: rtl/core_decode_comb.sv
// Combinational RV32I decoder: instruction word to one-hot flags, register
// indices and immediate. pc is left zero for the caller to fill in.
module core_decode_comb
    import core_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    logic        bad;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt = {27'b0, inst[24:20]};

    always_comb begin
        dec = '0;
        bad = 1'b0;
        case (opc)
            OPC_OPIMM: begin
                dec.rd  = inst[11:7];
                dec.rs1 = inst[19:15];
                dec.imm = imm_i;
                case (f3)
                    F3_ADD:  dec.op[F_ADDI]  = 1'b1;
                    F3_SLT:  dec.op[F_SLTI]  = 1'b1;
                    F3_SLTU: dec.op[F_SLTIU] = 1'b1;
                    F3_XOR:  dec.op[F_XORI]  = 1'b1;
                    F3_OR:   dec.op[F_ORI]   = 1'b1;
                    F3_AND:  dec.op[F_ANDI]  = 1'b1;
                    F3_SLL: begin
                        dec.imm = shamt;
                        if (f7 == F7_ZERO) dec.op[F_SLLI] = 1'b1;
                        else               bad = 1'b1;
                    end
                    default: begin
                        dec.imm = shamt;
                        if (f7 == F7_ZERO)     dec.op[F_SRLI] = 1'b1;
                        else if (f7 == F7_ALT) dec.op[F_SRAI] = 1'b1;
                        else                   bad = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec.rd  = inst[11:7];
                dec.rs1 = inst[19:15];
                dec.rs2 = inst[24:20];
                if (f7 == F7_ZERO) begin
                    case (f3)
                        F3_ADD:  dec.op[F_ADD]  = 1'b1;
                        F3_SLL:  dec.op[F_SLL]  = 1'b1;
                        F3_SLT:  dec.op[F_SLT]  = 1'b1;
                        F3_SLTU: dec.op[F_SLTU] = 1'b1;
                        F3_XOR:  dec.op[F_XOR]  = 1'b1;
                        F3_SR:   dec.op[F_SRL]  = 1'b1;
                        F3_OR:   dec.op[F_OR]   = 1'b1;
                        default: dec.op[F_AND]  = 1'b1;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) dec.op[F_SUB] = 1'b1;
                else if (f7 == F7_ALT && f3 == F3_SR)      dec.op[F_SRA] = 1'b1;
                else                                       bad = 1'b1;
            end
            OPC_BRANCH: begin
                dec.rs1 = inst[19:15];
                dec.rs2 = inst[24:20];
                dec.imm = imm_b;
                case (f3)
                    F3_BEQ:  dec.op[F_BEQ]  = 1'b1;
                    F3_BNE:  dec.op[F_BNE]  = 1'b1;
                    F3_BLT:  dec.op[F_BLT]  = 1'b1;
                    F3_BGE:  dec.op[F_BGE]  = 1'b1;
                    F3_BLTU: dec.op[F_BLTU] = 1'b1;
                    F3_BGEU: dec.op[F_BGEU] = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.rd  = inst[11:7];
                dec.rs1 = inst[19:15];
                dec.imm = imm_i;
                case (f3)
                    F3_B:    dec.op[F_LB]  = 1'b1;
                    F3_H:    dec.op[F_LH]  = 1'b1;
                    F3_W:    dec.op[F_LW]  = 1'b1;
                    F3_BU:   dec.op[F_LBU] = 1'b1;
                    F3_HU:   dec.op[F_LHU] = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.rs1 = inst[19:15];
                dec.rs2 = inst[24:20];
                dec.imm = imm_s;
                case (f3)
                    F3_B:    dec.op[F_SB] = 1'b1;
                    F3_H:    dec.op[F_SH] = 1'b1;
                    F3_W:    dec.op[F_SW] = 1'b1;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec.rd  = inst[11:7];
                dec.imm = imm_u;
                dec.op[F_LUI] = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rd  = inst[11:7];
                dec.imm = imm_u;
                dec.op[F_AUIPC] = 1'b1;
            end
            OPC_JAL: begin
                dec.rd  = inst[11:7];
                dec.imm = imm_j;
                dec.op[F_JAL] = 1'b1;
            end
            OPC_JALR: begin
                dec.rd  = inst[11:7];
                dec.rs1 = inst[19:15];
                dec.imm = imm_i;
                if (f3 == 3'b000) dec.op[F_JALR] = 1'b1;
                else              bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // illegal words present a clean, all-zero record apart from the flag
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/core_decode.sv
// Decode stage: combinational decoder feeding a two-entry output/skid buffer so
// IN_READY is registered and throughput holds at one per cycle under stalls.
module core_decode
    import core_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     IN_INST,
    input  logic [PC_W-1:0] IN_PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [PC_W-1:0] OUT_PC,
    output logic [OP_W-1:0] OUT_OP,
    output logic [4:0]      OUT_RS1,
    output logic [4:0]      OUT_RS2,
    output logic [4:0]      OUT_RD,
    output logic [31:0]     OUT_IMM,
    output logic            OUT_ILLEGAL
);

    dec_t raw, in_dec, out_q, skid_q;
    logic out_v, skid_v, in_rdy;
    logic in_fire, out_free;

    core_decode_comb u_comb (
        .inst (IN_INST),
        .dec  (raw)
    );

    always_comb begin
        in_dec    = raw;
        in_dec.pc = PC_MAX_W'(IN_PC);
    end

    assign in_fire  = IN_VALID & in_rdy;
    assign out_free = ~out_v | OUT_READY;

    // in_rdy mirrors "skid empty"; a fire therefore never coincides with a full skid
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            in_rdy <= 1'b1;
            out_q  <= '0;
            skid_q <= '0;
        end else if (FLUSH) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            in_rdy <= 1'b1;
        end else if (out_free) begin
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
                in_rdy <= 1'b1;
            end else begin
                out_v <= in_fire;
                if (in_fire) out_q <= in_dec;
            end
        end else if (in_fire) begin
            skid_q <= in_dec;
            skid_v <= 1'b1;
            in_rdy <= 1'b0;
        end
    end

    assign IN_READY    = in_rdy;
    assign OUT_VALID   = out_v;
    assign OUT_PC      = out_q.pc[PC_W-1:0];
    assign OUT_OP      = out_q.op;
    assign OUT_RS1     = out_q.rs1;
    assign OUT_RS2     = out_q.rs2;
    assign OUT_RD      = out_q.rd;
    assign OUT_IMM     = out_q.imm;
    assign OUT_ILLEGAL = out_q.illegal;

endmodule

// File: tb/tb_core_decode.sv
// Bench for core_decode: table-driven RV32I reference decode plus a two-deep
// in-order queue model of the buffer, directed cases then random traffic.
module tb_core_decode;
    import core_pkg::*;

    logic            CLK = 1'b0;
    logic            RST_N, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_ILLEGAL;
    logic [31:0]     IN_INST, IN_PC, OUT_PC, OUT_IMM;
    logic [OP_W-1:0] OUT_OP;
    logic [4:0]      OUT_RS1, OUT_RS2, OUT_RD;

    core_decode #(.PC_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INST(IN_INST), .IN_PC(IN_PC),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC), .OUT_OP(OUT_OP),
        .OUT_RS1(OUT_RS1), .OUT_RS2(OUT_RS2), .OUT_RD(OUT_RD), .OUT_IMM(OUT_IMM),
        .OUT_ILLEGAL(OUT_ILLEGAL)
    );

    always #5 CLK = ~CLK;

    localparam int FR = 0, FI = 1, FSH = 2, FS = 3, FB = 4, FU = 5, FJ = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    int         checks = 0, errors = 0;
    item_t      q[$];
    logic [6:0] t_opc[OP_W];
    int         t_f3[OP_W], t_f7[OP_W], t_fmt[OP_W];

    task automatic add(input int i, input logic [6:0] opc, input int f3, input int f7, input int fmt);
        t_opc[i] = opc; t_f3[i] = f3; t_f7[i] = f7; t_fmt[i] = fmt;
    endtask

    // Reference: the first table row whose fixed fields match names the instruction
    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t e;
        int   hit;
        e   = '0;
        hit = -1;
        for (int i = 0; i < OP_W; i++)
            if (hit < 0 && w[6:0] == t_opc[i] && (t_f3[i] < 0 || int'(w[14:12]) == t_f3[i])
                && (t_f7[i] < 0 || int'(w[31:25]) == t_f7[i])) hit = i;
        if (hit < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.op[hit] = 1'b1;
        case (t_fmt[hit])
            FR:  begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
            FI:  begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = 32'($signed(w[31:20])); end
            FSH: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = 32'(w[24:20]); end
            FS:  begin e.rs1 = w[19:15]; e.rs2 = w[24:20];
                       e.imm = 32'($signed({w[31:25], w[11:7]})); end
            FB:  begin e.rs1 = w[19:15]; e.rs2 = w[24:20];
                       e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            FU:  begin e.rd = w[11:7]; e.imm = w & 32'hFFFFF000; end
            default: begin e.rd = w[11:7];
                       e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_front();
        dec_t e;
        e = ref_dec(q[0].inst);
        chk("out_pc", 64'(OUT_PC), 64'(q[0].pc));
        chk("out_op", 64'(OUT_OP), 64'(e.op));
        chk("out_illegal", 64'(OUT_ILLEGAL), 64'(e.illegal));
        chk("out_imm", 64'(OUT_IMM), 64'(e.imm));
        if (!e.illegal) begin
            chk("out_rs1", 64'(OUT_RS1), 64'(e.rs1));
            chk("out_rs2", 64'(OUT_RS2), 64'(e.rs2));
            chk("out_rd", 64'(OUT_RD), 64'(e.rd));
        end
    endtask

    // One clock: drive, predict transfers, advance model, sample #1 after the edge
    task automatic cyc(input logic vin, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
        logic  in_fire, out_fire;
        item_t it;
        IN_VALID = vin; IN_INST = inst; IN_PC = pc; OUT_READY = ordy; FLUSH = fl;
        in_fire  = vin && (q.size() < 2);
        out_fire = OUT_VALID && ordy;
        it.pc = pc; it.inst = inst;
        @(posedge CLK);
        if (out_fire && q.size() > 0) void'(q.pop_front());
        if (fl) q.delete();
        else if (in_fire) q.push_back(it);
        #1;
        chk("out_valid", 64'(OUT_VALID), 64'(q.size() > 0));
        chk("in_ready", 64'(IN_READY), 64'(q.size() < 2));
        if (q.size() > 0) chk_front();
    endtask

    task automatic do_reset();
        RST_N = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        q.delete();
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        chk("rst_data", 64'({OUT_PC, OUT_IMM} | 64'(OUT_OP) | 64'({OUT_RS1, OUT_RS2, OUT_RD, OUT_ILLEGAL})), 64'd0);
        RST_N = 1'b1;
    endtask

    function automatic logic [OP_W-1:0] onehot(input int i);
        logic [OP_W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [31:0] w;
        int          k;

        add(F_ADDI, OPC_OPIMM, 0, -1, FI);  add(F_SLTI, OPC_OPIMM, 2, -1, FI);
        add(F_SLTIU, OPC_OPIMM, 3, -1, FI); add(F_XORI, OPC_OPIMM, 4, -1, FI);
        add(F_ORI, OPC_OPIMM, 6, -1, FI);   add(F_ANDI, OPC_OPIMM, 7, -1, FI);
        add(F_SLLI, OPC_OPIMM, 1, 0, FSH);  add(F_SRLI, OPC_OPIMM, 5, 0, FSH);
        add(F_SRAI, OPC_OPIMM, 5, 32, FSH);
        add(F_ADD, OPC_OP, 0, 0, FR);  add(F_SUB, OPC_OP, 0, 32, FR); add(F_SLL, OPC_OP, 1, 0, FR);
        add(F_SLT, OPC_OP, 2, 0, FR);  add(F_SLTU, OPC_OP, 3, 0, FR); add(F_XOR, OPC_OP, 4, 0, FR);
        add(F_SRL, OPC_OP, 5, 0, FR);  add(F_SRA, OPC_OP, 5, 32, FR); add(F_OR, OPC_OP, 6, 0, FR);
        add(F_AND, OPC_OP, 7, 0, FR);
        add(F_BEQ, OPC_BRANCH, 0, -1, FB);  add(F_BNE, OPC_BRANCH, 1, -1, FB);
        add(F_BLT, OPC_BRANCH, 4, -1, FB);  add(F_BGE, OPC_BRANCH, 5, -1, FB);
        add(F_BLTU, OPC_BRANCH, 6, -1, FB); add(F_BGEU, OPC_BRANCH, 7, -1, FB);
        add(F_LB, OPC_LOAD, 0, -1, FI);  add(F_LH, OPC_LOAD, 1, -1, FI); add(F_LW, OPC_LOAD, 2, -1, FI);
        add(F_LBU, OPC_LOAD, 4, -1, FI); add(F_LHU, OPC_LOAD, 5, -1, FI);
        add(F_SB, OPC_STORE, 0, -1, FS); add(F_SH, OPC_STORE, 1, -1, FS); add(F_SW, OPC_STORE, 2, -1, FS);
        add(F_LUI, OPC_LUI, -1, -1, FU); add(F_AUIPC, OPC_AUIPC, -1, -1, FU);
        add(F_JAL, OPC_JAL, -1, -1, FJ); add(F_JALR, OPC_JALR, 0, -1, FI);

        IN_INST = '0; IN_PC = '0;
        do_reset();
        @(posedge CLK); #1;
        chk("post_rst_in_ready", 64'(IN_READY), 64'd1);
        chk("post_rst_out_valid", 64'(OUT_VALID), 64'd0);

        // directed decodes with literal expectations
        cyc(1, 32'hFFF10093, 32'h100, 1, 0);
        chk("addi_op", 64'(OUT_OP), 64'(onehot(F_ADDI)));
        chk("addi_imm", 64'(OUT_IMM), 64'hFFFFFFFF);
        chk("addi_regs", 64'({OUT_RS1, OUT_RS2, OUT_RD}), 64'({5'd2, 5'd0, 5'd1}));
        cyc(1, 32'h40335293, 32'h104, 1, 0);
        chk("srai_op", 64'(OUT_OP), 64'(onehot(F_SRAI)));
        chk("srai_imm", 64'(OUT_IMM), 64'd3);
        chk("srai_regs", 64'({OUT_RS1, OUT_RD}), 64'({5'd6, 5'd5}));
        cyc(1, 32'h00335293, 32'h108, 1, 0);
        chk("srli_op", 64'(OUT_OP), 64'(onehot(F_SRLI)));
        cyc(1, 32'hFE208EE3, 32'h10C, 1, 0);
        chk("beq_op", 64'(OUT_OP), 64'(onehot(F_BEQ)));
        chk("beq_imm", 64'(OUT_IMM), 64'hFFFFFFFC);
        chk("beq_regs", 64'({OUT_RS1, OUT_RS2, OUT_RD}), 64'({5'd1, 5'd2, 5'd0}));
        cyc(1, 32'h00000000, 32'h110, 1, 0);
        chk("ill0", 64'({OUT_VALID, OUT_ILLEGAL, OUT_IMM}), 64'({1'b1, 1'b1, 32'd0}));
        chk("ill0_op", 64'(OUT_OP), 64'd0);
        cyc(1, 32'h02000033, 32'h114, 1, 0);
        chk("ill_f7", 64'({OUT_VALID, OUT_ILLEGAL}), 64'({1'b1, 1'b1}));
        chk("ill_f7_op", 64'(OUT_OP), 64'd0);
        cyc(0, 0, 0, 1, 0);

        // streaming under backpressure: 0, 4, 8 with three stalled cycles
        cyc(1, 32'h00100093, 32'd0, 0, 0);
        cyc(1, 32'h00200113, 32'd4, 0, 0);
        chk("bp_in_ready_low", 64'(IN_READY), 64'd0);
        cyc(1, 32'h00300193, 32'd8, 0, 0);
        chk("bp_hold_pc", 64'(OUT_PC), 64'd0);
        cyc(1, 32'h00300193, 32'd8, 1, 0);
        chk("bp_drain_pc4", 64'(OUT_PC), 64'd4);
        cyc(1, 32'h00300193, 32'd8, 1, 0);
        chk("bp_drain_pc8", 64'(OUT_PC), 64'd8);
        cyc(0, 0, 0, 1, 0);
        chk("bp_empty", 64'(OUT_VALID), 64'd0);

        // flush with both entries full and a concurrent input
        cyc(1, 32'h00100093, 32'h20, 0, 0);
        cyc(1, 32'h00200113, 32'h24, 0, 0);
        cyc(1, 32'h00300193, 32'h28, 0, 1);
        chk("flush_valid", 64'(OUT_VALID), 64'd0);
        chk("flush_ready", 64'(IN_READY), 64'd1);
        repeat (3) cyc(0, 0, 0, 1, 0);
        // flush alongside an output transfer
        cyc(1, 32'h00100093, 32'h40, 0, 0);
        cyc(1, 32'h00200113, 32'h44, 0, 0);
        cyc(1, 32'h00300193, 32'h48, 1, 1);
        cyc(1, 32'h00400213, 32'h4C, 1, 0);
        chk("post_flush_pc", 64'(OUT_PC), 64'h4C);
        cyc(0, 0, 0, 1, 0);

        // reset mid-stream
        cyc(1, 32'h00100093, 32'h60, 0, 0);
        cyc(1, 32'h00200113, 32'h64, 0, 0);
        do_reset();
        cyc(0, 0, 0, 1, 0);

        // random traffic
        for (int n = 0; n < 10000; n++) begin
            w = $urandom;
            if ($urandom_range(9) < 8) begin
                k = $urandom_range(OP_W - 1);
                w[6:0] = t_opc[k];
                if (t_f3[k] >= 0) w[14:12] = 3'(t_f3[k]);
                if (t_f7[k] >= 0) w[31:25] = 7'(t_f7[k]);
            end
            cyc($urandom_range(9) < 7, w, $urandom & 32'hFFFFFFFC,
                $urandom_range(9) < 6, $urandom_range(63) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
